// File: rtl/rom_fetch_cache.sv
// ROM fetch stage: maps ROM-local addresses to SDRAM word addresses, runs the
// req/ack/valid handshake with the arbiter and keeps a small direct-mapped word cache.
module rom_fetch_cache #(
   parameter int          ROM_ADDR_WIDTH = 19,
   parameter int          ROM_DATA_WIDTH = 16,
   parameter logic [23:0] ROM_OFFSET     = 24'h000000,
   parameter int          LINES          = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_cs,
   input  logic                      i_oe,
   input  logic [ROM_ADDR_WIDTH-1:0] i_rom_addr,
   output logic [ROM_DATA_WIDTH-1:0] o_rom_data,
   input  logic                      i_invalidate,
   output logic [22:0]               o_ctrl_addr,
   output logic                      o_ctrl_req,
   input  logic                      i_ctrl_ack,
   input  logic                      i_ctrl_valid,
   input  logic [31:0]               i_ctrl_data,
   output logic                      o_ctrl_hit
);

   localparam int          AW    = ROM_ADDR_WIDTH;
   localparam int          IDX_W = $clog2(LINES);
   localparam int          TAG_W = 23 - IDX_W;
   localparam logic [22:0] OFF_W = 23'(ROM_OFFSET >> 2);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t             r_state, w_next;
   logic [22:0]        r_addr;
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [31:0]        r_data [LINES];

   logic [22:0]        w_word;
   logic [IDX_W-1:0]   w_idx, w_fill_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit, w_fill, w_start, w_bypass;
   logic [31:0]        w_src;

   generate
      if (ROM_DATA_WIDTH == 32) begin : g_map32
         assign w_word = OFF_W + 23'(i_rom_addr);
      end else begin : g_map16
         assign w_word = OFF_W + 23'(i_rom_addr[AW-1:1]);
      end
   endgenerate

   assign w_idx      = w_word[IDX_W-1:0];
   assign w_tag      = w_word[22:IDX_W];
   assign w_fill_idx = r_addr[IDX_W-1:0];
   assign w_hit      = i_cs & i_oe & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

   // A valid coinciding with the ack in REQ completes the request as if in WAIT.
   assign w_fill   = i_ctrl_valid & ((r_state == S_WAIT) | ((r_state == S_REQ) & i_ctrl_ack));
   assign w_start  = (r_state == S_IDLE) & i_cs & i_oe & ~w_hit;
   assign w_bypass = w_fill & (w_word == r_addr);

   always_comb begin
      w_next     = r_state;
      o_ctrl_req = 1'b0;
      case (r_state)
         S_IDLE: if (w_start) w_next = S_REQ;
         S_REQ: begin
            o_ctrl_req = 1'b1;
            if (w_fill)          w_next = S_IDLE;
            else if (i_ctrl_ack) w_next = S_WAIT;
         end
         S_WAIT: if (i_ctrl_valid) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) r_addr <= w_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_valid <= '0;
      else if (i_invalidate)
         r_valid <= '0;
      else if (w_fill)
         r_valid[w_fill_idx] <= 1'b1;
   end

   // Tag/data need no reset; they are only read behind a valid bit.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_fill_idx]  <= r_addr[22:IDX_W];
         r_data[w_fill_idx] <= i_ctrl_data;
      end
   end

   assign w_src      = w_bypass ? i_ctrl_data : r_data[w_idx];
   assign o_ctrl_hit = w_hit;
   assign o_ctrl_addr = r_addr;

   generate
      if (ROM_DATA_WIDTH == 32) begin : g_out32
         assign o_rom_data = (w_bypass | w_hit) ? w_src : '0;
      end else begin : g_out16
         // Big-endian lanes: even halfword lives in the upper half of the SDRAM word.
         assign o_rom_data = (w_bypass | w_hit) ?
                             (i_rom_addr[0] ? w_src[15:0] : w_src[31:16]) : '0;
      end
   endgenerate

endmodule

// File: tb/tb_rom_fetch_cache.sv
// Bench for rom_fetch_cache: address-map table, directed handshake sequences on
// 16- and 32-bit instances, and a randomized run against a transaction-level model.
module tb_rom_fetch_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, oe, inv, ack, vld;
   logic [18:0] addr;
   logic [31:0] cdata;

   logic [15:0] d16;
   logic [31:0] d32;
   logic [22:0] ca16, ca32;
   logic        req16, req32, hit16, hit32;

   logic        sel;
   logic [31:0] cur_data;
   logic [22:0] cur_caddr;
   logic        cur_req, cur_hit;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rom_fetch_cache #(.ROM_ADDR_WIDTH(19), .ROM_DATA_WIDTH(16), .ROM_OFFSET(24'h000000), .LINES(4)) u16 (
      .clk(clk), .reset(reset), .i_cs(cs), .i_oe(oe), .i_rom_addr(addr), .o_rom_data(d16),
      .i_invalidate(inv), .o_ctrl_addr(ca16), .o_ctrl_req(req16), .i_ctrl_ack(ack),
      .i_ctrl_valid(vld), .i_ctrl_data(cdata), .o_ctrl_hit(hit16));

   rom_fetch_cache #(.ROM_ADDR_WIDTH(19), .ROM_DATA_WIDTH(32), .ROM_OFFSET(24'h080000), .LINES(4)) u32 (
      .clk(clk), .reset(reset), .i_cs(cs), .i_oe(oe), .i_rom_addr(addr), .o_rom_data(d32),
      .i_invalidate(inv), .o_ctrl_addr(ca32), .o_ctrl_req(req32), .i_ctrl_ack(ack),
      .i_ctrl_valid(vld), .i_ctrl_data(cdata), .o_ctrl_hit(hit32));

   assign cur_data  = sel ? d32 : {16'h0, d16};
   assign cur_caddr = sel ? ca32 : ca16;
   assign cur_req   = sel ? req32 : req16;
   assign cur_hit   = sel ? hit32 : hit16;

   typedef struct {
      logic        s;
      logic [18:0] a;
      logic [22:0] w;
   } vec_t;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lane(input logic s, input logic [18:0] a, input logic [31:0] d);
      return s ? d : {16'h0, (a[0] ? d[15:0] : d[31:16])};
   endfunction

   function automatic logic [31:0] mem(input logic [22:0] w);
      return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic do_reset();
      reset = 1'b1; cs = 0; oe = 0; addr = '0; inv = 0; ack = 0; vld = 0; cdata = '0;
      tick();
      @(negedge clk);
      chk("rst_req", 32'(cur_req), 0);
      chk("rst_addr", 32'(cur_caddr), 0);
      tick();
      reset = 1'b0;
   endtask

   // Miss, request, ack after ad cycles, valid vd cycles later, then the hit cycle.
   task automatic fetch(input logic [18:0] a, input logic [22:0] ew, input int ad, input int vd,
                        input logic [31:0] d);
      cs = 1; oe = 1; addr = a;
      @(negedge clk);
      chk("miss_hit", 32'(cur_hit), 0);
      tick();
      @(negedge clk);
      chk("req_up", 32'(cur_req), 1);
      chk("req_addr", 32'(cur_caddr), 32'(ew));
      repeat (ad) tick();
      @(negedge clk);
      chk("req_hold", 32'(cur_req), 1);
      ack = 1;
      tick();
      ack = 0;
      @(negedge clk);
      chk("req_drop", 32'(cur_req), 0);
      repeat (vd) tick();
      vld = 1; cdata = d;
      @(negedge clk);
      chk("bypass", cur_data, lane(sel, a, d));
      tick();
      vld = 0; cdata = '0;
      @(negedge clk);
      chk("fill_hit", 32'(cur_hit), 1);
      chk("fill_data", cur_data, lane(sel, a, d));
      chk("fill_noreq", 32'(cur_req), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      tbl[0] = '{1'b0, 19'h00003, 23'h000001};
      tbl[1] = '{1'b0, 19'h00100, 23'h000080};
      tbl[2] = '{1'b0, 19'h7FFFF, 23'h03FFFF};
      tbl[3] = '{1'b1, 19'h00010, 23'h020010};
      tbl[4] = '{1'b1, 19'h00000, 23'h020000};
      tbl[5] = '{1'b1, 19'h7FFFF, 23'h09FFFF};

      sel = 0;
      reset = 1'b1;
      do_reset();

      // Address mapping from a cold cache
      for (int i = 0; i < 6; i++) begin
         sel = tbl[i].s;
         do_reset();
         cs = 1; oe = 1; addr = tbl[i].a;
         @(negedge clk);
         chk("tbl_hit", 32'(cur_hit), 0);
         chk("tbl_data", cur_data, 0);
         chk("tbl_req0", 32'(cur_req), 0);
         tick();
         @(negedge clk);
         chk("tbl_req1", 32'(cur_req), 1);
         chk("tbl_addr", 32'(cur_caddr), 32'(tbl[i].w));
      end

      // 16-bit lane on fill
      sel = 0; do_reset();
      fetch(19'h00003, 23'h000001, 2, 3, 32'hAABBCCDD);

      // 32-bit with offset, refetch hits, then same-index eviction
      sel = 1; do_reset();
      fetch(19'h00010, 23'h020010, 0, 1, 32'h12345678);
      repeat (3) begin
         tick();
         @(negedge clk);
         chk("rehit", 32'(cur_hit), 1);
         chk("rehit_req", 32'(cur_req), 0);
         chk("rehit_data", cur_data, 32'h12345678);
      end
      tick();
      fetch(19'h00014, 23'h020014, 1, 0, 32'h87654321);
      tick();
      addr = 19'h00010;
      @(negedge clk);
      chk("evict_hit", 32'(cur_hit), 0);
      tick();
      @(negedge clk);
      chk("evict_req", 32'(cur_req), 1);
      chk("evict_addr", 32'(cur_caddr), 32'h020010);

      // Address change during WAIT: fill lands on latched address, new miss from IDLE only
      sel = 0; do_reset();
      cs = 1; oe = 1; addr = 19'h00001;
      tick();
      @(negedge clk);
      chk("chg_addr", 32'(cur_caddr), 0);
      ack = 1;
      tick();
      ack = 0; addr = 19'h00100;
      @(negedge clk);
      chk("chg_req_w", 32'(cur_req), 0);
      tick();
      vld = 1; cdata = 32'h11223344;
      @(negedge clk);
      chk("chg_nobyp", cur_data, 0);
      chk("chg_req_w2", 32'(cur_req), 0);
      tick();
      vld = 0; addr = 19'h00001;
      @(negedge clk);
      chk("chg_stored", 32'(cur_hit), 1);
      chk("chg_sdata", cur_data, 32'h3344);
      tick();
      addr = 19'h00100;
      @(negedge clk);
      chk("chg_idle", 32'(cur_req), 0);
      tick();
      @(negedge clk);
      chk("chg_req", 32'(cur_req), 1);
      chk("chg_naddr", 32'(cur_caddr), 32'h000080);

      // Invalidate after two fills, then invalidate coinciding with a fill
      sel = 0; do_reset();
      fetch(19'h00000, 23'h000000, 1, 1, 32'hA1A2A3A4);
      tick();
      fetch(19'h00002, 23'h000001, 1, 1, 32'hB1B2B3B4);
      cs = 0; oe = 0; inv = 1;
      tick();
      inv = 0; cs = 1; oe = 1; addr = 19'h00000;
      @(negedge clk);
      chk("inv_hit0", 32'(cur_hit), 0);
      addr = 19'h00002;
      #2;
      chk("inv_hit1", 32'(cur_hit), 0);
      tick();
      @(negedge clk);
      chk("inv_req", 32'(cur_req), 1);
      chk("inv_addr", 32'(cur_caddr), 32'h000001);
      ack = 1;
      tick();
      ack = 0; vld = 1; inv = 1; cdata = 32'hC1C2C3C4;
      @(negedge clk);
      chk("inv_byp", cur_data, 32'h0000C1C2);
      tick();
      vld = 0; inv = 0;
      @(negedge clk);
      chk("inv_nofill", 32'(cur_hit), 0);

      // Reset during WAIT, late valid ignored
      sel = 0; do_reset();
      cs = 1; oe = 1; addr = 19'h00020;
      tick();
      ack = 1;
      tick();
      ack = 0; reset = 1;
      #1;
      chk("rw_req", 32'(cur_req), 0);
      chk("rw_addr", 32'(cur_caddr), 0);
      chk("rw_hit", 32'(cur_hit), 0);
      tick();
      reset = 0; cs = 0; oe = 0; vld = 1; cdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("rw_data", cur_data, 0);
      chk("rw_req2", 32'(cur_req), 0);
      tick();
      vld = 0; cs = 1; oe = 1;
      @(negedge clk);
      chk("rw_nofill", 32'(cur_hit), 0);
      chk("rw_data2", cur_data, 0);

      // Randomized run against a transaction-level model (16-bit instance)
      begin
         bit          m_v[4];
         logic [22:0] m_w[4];
         logic [31:0] m_d[4];
         bit          m_busy, m_ack, mh, comp;
         logic [22:0] m_pa, w;
         logic [31:0] ed;
         int          ix;
         sel = 0; do_reset();
         m_busy = 0; m_ack = 0; m_pa = '0;
         for (int i = 0; i < 4; i++) m_v[i] = 0;
         for (int c = 0; c < 1500; c++) begin
            cs    = ($urandom_range(0, 9) < 8);
            oe    = ($urandom_range(0, 9) < 9);
            addr  = 19'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 19'h01000 : 19'h0);
            inv   = ($urandom_range(0, 39) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            vld   = ($urandom_range(0, 2) == 0);
            cdata = m_busy ? mem(m_pa) : $urandom;
            @(negedge clk);
            w    = 23'(addr >> 1);
            ix   = int'(w % 4);
            mh   = cs && oe && m_v[ix] && (m_w[ix] == w);
            comp = m_busy && vld && (m_ack || ack);
            if (comp && (w == m_pa)) ed = lane(1'b0, addr, mem(m_pa));
            else if (mh)             ed = lane(1'b0, addr, m_d[ix]);
            else                     ed = '0;
            chk("rnd_hit", 32'(cur_hit), 32'(mh));
            chk("rnd_data", cur_data, ed);
            chk("rnd_req", 32'(cur_req), 32'(m_busy && !m_ack));
            chk("rnd_addr", 32'(cur_caddr), 32'(m_pa));
            if (inv) begin
               for (int k = 0; k < 4; k++) m_v[k] = 0;
            end else if (comp) begin
               m_v[m_pa % 4] = 1;
               m_w[m_pa % 4] = m_pa;
               m_d[m_pa % 4] = mem(m_pa);
            end
            if (comp)                            m_busy = 0;
            else if (m_busy && !m_ack && ack)    m_ack = 1;
            else if (!m_busy && cs && oe && !mh) begin
               m_busy = 1; m_ack = 0; m_pa = w;
            end
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
